// File: rtl/reg_wr_arbiter.sv
// Write-port arbiter for one shared enabled register: round-robin data writes
// among N_REQ requesters, with sticky clear/preset commands that take priority.
module reg_wr_arbiter #(
  parameter int N_REQ = 4,
  parameter int DW    = 8,
  parameter int IDW   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] wdata,
  input  logic                clr_req,
  input  logic                set_req,
  output logic [N_REQ-1:0]    gnt,
  output logic [IDW-1:0]      gnt_id,
  output logic                reg_we,
  output logic [DW-1:0]       reg_d,
  output logic                reg_clr,
  output logic                reg_set,
  output logic                busy,
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_SET   = 3'd2,
    S_GUARD = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t             state_q, state_n;
  logic               clr_pend_q, clr_pend_n;
  logic               set_pend_q, set_pend_n;
  logic [IDW-1:0]     ptr_q, ptr_n;

  logic               clr_eff, set_eff;
  logic [N_REQ-1:0]   elig;
  logic               found;
  logic [IDW-1:0]     win;

  logic [N_REQ-1:0]   gnt_n;
  logic [IDW-1:0]     gnt_id_n;
  logic               reg_we_n, reg_clr_n, reg_set_n, busy_n;
  logic [DW-1:0]      reg_d_n;

  // Handshake: a write transfers when req[i] and gnt[i] are both high at a
  // rising edge; the requester holds req until then and may drop it after.
  // The requester granted this cycle sits out the next arbitration.
  assign clr_eff = clr_pend_q | clr_req;
  assign set_eff = set_pend_q | set_req;
  assign elig    = req & ((state_q == S_WRITE) ? ~gnt : {N_REQ{1'b1}});

  // Round-robin search starting at the pointer, wrapping modulo N_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  // Next-state: commands always win the evaluation, then data writes.
  always_comb begin
    state_n    = state_q;
    clr_pend_n = clr_eff;
    set_pend_n = set_eff;
    ptr_n      = ptr_q;
    case (state_q)
      S_CLR, S_SET: state_n = S_GUARD;
      default: begin
        if (clr_eff) begin
          state_n    = S_CLR;
          clr_pend_n = 1'b0;
        end else if (set_eff) begin
          state_n    = S_SET;
          set_pend_n = 1'b0;
        end else if (found) begin
          state_n = S_WRITE;
          ptr_n   = (win == IDW'(N_REQ - 1)) ? '0 : win + IDW'(1);
        end else begin
          state_n = S_IDLE;
        end
      end
    endcase
  end

  // Output values for the coming cycle; registered together with the state.
  always_comb begin
    gnt_n     = '0;
    gnt_id_n  = gnt_id;
    reg_we_n  = 1'b0;
    reg_d_n   = reg_d;
    reg_clr_n = (state_n == S_CLR);
    reg_set_n = (state_n == S_SET);
    if (state_n == S_WRITE) begin
      gnt_n[win] = 1'b1;
      gnt_id_n   = win;
      reg_we_n   = 1'b1;
      reg_d_n    = wdata[win*DW +: DW];
    end
    busy_n = clr_pend_n | set_pend_n |
             (state_n == S_CLR) | (state_n == S_SET) | (state_n == S_GUARD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      clr_pend_q <= 1'b0;
      set_pend_q <= 1'b0;
      ptr_q      <= '0;
      gnt        <= '0;
      gnt_id     <= '0;
      reg_we     <= 1'b0;
      reg_d      <= '0;
      reg_clr    <= 1'b0;
      reg_set    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_n;
      clr_pend_q <= clr_pend_n;
      set_pend_q <= set_pend_n;
      ptr_q      <= ptr_n;
      gnt        <= gnt_n;
      gnt_id     <= gnt_id_n;
      reg_we     <= reg_we_n;
      reg_d      <= reg_d_n;
      reg_clr    <= reg_clr_n;
      reg_set    <= reg_set_n;
      busy       <= busy_n;
    end
  end

  assign dbg_state = state_q;

endmodule
